// File: rtl/twiddle_fetch_ctrl_if.sv
// Handshake and ROM bus of the twiddle fetch controller.
// master: the controller; slave: the ROM and downstream butterfly side.
interface twiddle_fetch_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic              out_ready;
    logic [2:0]        rom_index;
    logic [DATA_W-1:0] rom_wreal;
    logic [DATA_W-1:0] rom_wimag;
    logic              tw_valid;
    logic [DATA_W-1:0] tw_real;
    logic [DATA_W-1:0] tw_imag;
    logic [1:0]        stage;
    logic [2:0]        addr_a;
    logic [2:0]        addr_b;
    logic              last;
    logic              busy;
    logic              done;

    modport master (
        input  start, out_ready, rom_wreal, rom_wimag,
        output rom_index, tw_valid, tw_real, tw_imag, stage,
               addr_a, addr_b, last, busy, done
    );

    modport slave (
        output start, out_ready, rom_wreal, rom_wimag,
        input  rom_index, tw_valid, tw_real, tw_imag, stage,
               addr_a, addr_b, last, busy, done
    );
endinterface

// File: rtl/twiddle_fetch_ctrl.sv
// Twiddle fetch controller for an 8-point radix-2 DIT FFT.
// Walks 12 butterflies (3 stages x 4), addresses a registered twiddle ROM
// and presents one beat per butterfly through a valid/ready output stage.
module twiddle_fetch_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    twiddle_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state_reg;
    logic [3:0]        cnt_reg;

    // P1: metadata of the issued butterfly plus a private copy of its ROM word
    logic              p1_valid_reg;
    logic              p1_fresh_reg;
    logic [1:0]        p1_stage_reg;
    logic [2:0]        p1_a_reg;
    logic [2:0]        p1_b_reg;
    logic              p1_last_reg;
    logic [DATA_W-1:0] p1_re_reg;
    logic [DATA_W-1:0] p1_im_reg;

    // Output stage
    logic              tw_valid_reg;
    logic [DATA_W-1:0] tw_real_reg;
    logic [DATA_W-1:0] tw_imag_reg;
    logic [1:0]        stage_reg;
    logic [2:0]        addr_a_reg;
    logic [2:0]        addr_b_reg;
    logic              last_reg;
    logic              busy_reg;
    logic              done_reg;

    logic              advance;
    logic              handshake;
    logic              issue;
    logic [1:0]        cur_stage;
    logic [1:0]        cur_j;
    logic [2:0]        cur_k;
    logic [2:0]        cur_a;
    logic [2:0]        cur_b;
    logic [DATA_W-1:0] p1_re_now;
    logic [DATA_W-1:0] p1_im_now;

    assign advance   = ~tw_valid_reg | bus.out_ready;
    assign handshake = tw_valid_reg & bus.out_ready;
    assign issue     = (state_reg == ISSUE) & advance;
    assign cur_stage = cnt_reg[3:2];
    assign cur_j     = cnt_reg[1:0];

    // The ROM word belongs to P1 only in the cycle right after the issue
    // edge; once P1 stalls, the copy taken at the following edge is used,
    // so the ROM address is free to move on (or drop to 0 in DRAIN).
    assign p1_re_now = p1_fresh_reg ? bus.rom_wreal : p1_re_reg;
    assign p1_im_now = p1_fresh_reg ? bus.rom_wimag : p1_im_reg;

    // Twiddle exponent and operand addresses of the butterfly at cnt_reg
    always_comb begin
        cur_k = 3'd0;
        cur_a = 3'd0;
        cur_b = 3'd0;
        case (cur_stage)
            2'd0: begin
                cur_k = 3'd0;
                cur_a = {cur_j, 1'b0};
                cur_b = {cur_j, 1'b1};
            end
            2'd1: begin
                cur_k = {1'b0, cur_j[0], 1'b0};
                cur_a = {cur_j[1], 1'b0, cur_j[0]};
                cur_b = {cur_j[1], 1'b1, cur_j[0]};
            end
            default: begin
                cur_k = {1'b0, cur_j};
                cur_a = {1'b0, cur_j};
                cur_b = {1'b1, cur_j};
            end
        endcase
    end

    assign bus.rom_index = (state_reg == ISSUE) ? cur_k : 3'd0;

    // Sequencer, P1 and output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            p1_valid_reg <= 1'b0;
            p1_fresh_reg <= 1'b0;
            p1_stage_reg <= 2'd0;
            p1_a_reg     <= 3'd0;
            p1_b_reg     <= 3'd0;
            p1_last_reg  <= 1'b0;
            p1_re_reg    <= '0;
            p1_im_reg    <= '0;
            tw_valid_reg <= 1'b0;
            tw_real_reg  <= '0;
            tw_imag_reg  <= '0;
            stage_reg    <= 2'd0;
            addr_a_reg   <= 3'd0;
            addr_b_reg   <= 3'd0;
            last_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped
                    if (bus.start && !done_reg) begin
                        state_reg <= ISSUE;
                        cnt_reg   <= 4'd0;
                        busy_reg  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (advance) begin
                        if (cnt_reg == 4'd11) begin
                            state_reg <= DRAIN;
                            cnt_reg   <= 4'd0;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake && last_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (p1_fresh_reg) begin
                p1_re_reg <= bus.rom_wreal;
                p1_im_reg <= bus.rom_wimag;
            end
            p1_fresh_reg <= issue;

            if (advance) begin
                p1_valid_reg <= issue;
                if (issue) begin
                    p1_stage_reg <= cur_stage;
                    p1_a_reg     <= cur_a;
                    p1_b_reg     <= cur_b;
                    p1_last_reg  <= (cnt_reg == 4'd11);
                end
                tw_valid_reg <= p1_valid_reg;
                if (p1_valid_reg) begin
                    tw_real_reg <= p1_re_now;
                    tw_imag_reg <= p1_im_now;
                    stage_reg   <= p1_stage_reg;
                    addr_a_reg  <= p1_a_reg;
                    addr_b_reg  <= p1_b_reg;
                    last_reg    <= p1_last_reg;
                end else begin
                    last_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.tw_valid = tw_valid_reg;
    assign bus.tw_real  = tw_real_reg;
    assign bus.tw_imag  = tw_imag_reg;
    assign bus.stage    = stage_reg;
    assign bus.addr_a   = addr_a_reg;
    assign bus.addr_b   = addr_b_reg;
    assign bus.last     = last_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// Bench for twiddle_fetch_ctrl: table of expected beats, registered ROM
// model, directed stall/start/reset sequences and random back-pressure.
module tb_twiddle_fetch_ctrl;
    localparam int DW = 16;

    logic clk;
    logic rst_n;

    twiddle_fetch_ctrl_if #(.DATA_W(DW)) bus ();

    twiddle_fetch_ctrl #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected beat record: input is the beat number (array position)
    typedef struct packed {
        logic [2:0] k;
        logic [1:0] s;
        logic [2:0] a;
        logic [2:0] b;
        logic       last;
    } beat_t;

    beat_t exp_tab [12];

    function automatic logic [DW-1:0] rom_re(input logic [2:0] k);
        logic [DW-1:0] kk;
        kk = {13'd0, k};
        return 16'h1100 * (kk + 16'd1);
    endfunction

    function automatic logic [DW-1:0] rom_im(input logic [2:0] k);
        logic [DW-1:0] kk;
        kk = {13'd0, k};
        return 16'hF000 - 16'h0101 * kk;
    endfunction

    // Registered twiddle ROM model
    logic [DW-1:0] rom_re_q;
    logic [DW-1:0] rom_im_q;
    always @(posedge clk) begin
        rom_re_q <= rom_re(bus.rom_index);
        rom_im_q <= rom_im(bus.rom_index);
    end
    assign bus.rom_wreal = rom_re_q;
    assign bus.rom_wimag = rom_im_q;

    int   checks = 0;
    int   errors = 0;
    int   beat_idx = 0;
    int   hs_count = 0;
    int   done_count = 0;
    logic last_hs = 1'b0;
    logic [2:0] smp_rom;
    logic smp_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Mid-cycle sample: current beat against the table, note the handshake
    task automatic mon_pre();
        beat_t e;
        smp_rom   = bus.rom_index;
        smp_valid = bus.tw_valid;
        last_hs   = 1'b0;
        if (bus.tw_valid) begin
            if (beat_idx > 11) begin
                chk("beat_overrun", beat_idx, 11);
            end else begin
                e = exp_tab[beat_idx];
                chk("stage",   {30'd0, bus.stage},  {30'd0, e.s});
                chk("addr_a",  {29'd0, bus.addr_a}, {29'd0, e.a});
                chk("addr_b",  {29'd0, bus.addr_b}, {29'd0, e.b});
                chk("last",    {31'd0, bus.last},   {31'd0, e.last});
                chk("tw_real", {16'd0, bus.tw_real}, {16'd0, rom_re(e.k)});
                chk("tw_imag", {16'd0, bus.tw_imag}, {16'd0, rom_im(e.k)});
                chk("busy_in_beat", {31'd0, bus.busy}, 32'd1);
            end
            if (bus.out_ready) begin
                hs_count++;
                last_hs = (beat_idx == 11);
                beat_idx++;
            end
        end
    endtask

    // After-edge sample: done must follow exactly the last-beat handshake
    task automatic mon_post();
        chk("done", {31'd0, bus.done}, {31'd0, last_hs});
        if (bus.done) begin
            done_count++;
            chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
            beat_idx = 0;
        end
    endtask

    // One clock: drive at edge+1, sample at the falling edge, then after edge
    task automatic cycle(input logic rdy, input logic st);
        bus.out_ready = rdy;
        bus.start     = st;
        #4;
        mon_pre();
        @(posedge clk);
        #1;
        mon_post();
    endtask

    task automatic run_to_done(input bit rand_rdy, input int budget);
        int  d0;
        bit  got;
        logic rdy;
        d0  = done_count;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle(rdy, 1'b0);
            if (done_count > d0) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tw_valid"},  {31'd0, bus.tw_valid}, 32'd0);
        chk({tag, "_tw_real"},   {16'd0, bus.tw_real},  32'd0);
        chk({tag, "_tw_imag"},   {16'd0, bus.tw_imag},  32'd0);
        chk({tag, "_stage"},     {30'd0, bus.stage},    32'd0);
        chk({tag, "_addr_a"},    {29'd0, bus.addr_a},   32'd0);
        chk({tag, "_addr_b"},    {29'd0, bus.addr_b},   32'd0);
        chk({tag, "_last"},      {31'd0, bus.last},     32'd0);
        chk({tag, "_busy"},      {31'd0, bus.busy},     32'd0);
        chk({tag, "_done"},      {31'd0, bus.done},     32'd0);
        chk({tag, "_rom_index"}, {29'd0, bus.rom_index}, 32'd0);
    endtask

    initial begin
        int  hs0;
        int  d0;
        int  stall_left;
        logic rdy;
        logic st;
        bit  found;

        //                k     s     a     b     last
        exp_tab[0]  = {3'd0, 2'd0, 3'd0, 3'd1, 1'b0};
        exp_tab[1]  = {3'd0, 2'd0, 3'd2, 3'd3, 1'b0};
        exp_tab[2]  = {3'd0, 2'd0, 3'd4, 3'd5, 1'b0};
        exp_tab[3]  = {3'd0, 2'd0, 3'd6, 3'd7, 1'b0};
        exp_tab[4]  = {3'd0, 2'd1, 3'd0, 3'd2, 1'b0};
        exp_tab[5]  = {3'd2, 2'd1, 3'd1, 3'd3, 1'b0};
        exp_tab[6]  = {3'd0, 2'd1, 3'd4, 3'd6, 1'b0};
        exp_tab[7]  = {3'd2, 2'd1, 3'd5, 3'd7, 1'b0};
        exp_tab[8]  = {3'd0, 2'd2, 3'd0, 3'd4, 1'b0};
        exp_tab[9]  = {3'd1, 2'd2, 3'd1, 3'd5, 1'b0};
        exp_tab[10] = {3'd2, 2'd2, 3'd2, 3'd6, 1'b0};
        exp_tab[11] = {3'd3, 2'd2, 3'd3, 3'd7, 1'b1};

        // Reset state
        rst_n = 1'b1;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back run: latency, rom_index order, 12 beats, one done
        hs0 = hs_count;
        d0  = done_count;
        cycle(1'b1, 1'b1);
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 1'b0);
            chk($sformatf("rom_index_%0d", i), {29'd0, smp_rom},
                (i < 12) ? {29'd0, exp_tab[i].k} : 32'd0);
            chk($sformatf("valid_%0d", i), {31'd0, smp_valid}, (i >= 2) ? 32'd1 : 32'd0);
        end
        chk("b2b_beats", hs_count - hs0, 12);
        chk("b2b_dones", done_count - d0, 1);
        // start while done is high is dropped
        cycle(1'b1, 1'b1);
        chk("start_at_done_busy", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        chk("start_at_done_beats", hs_count - hs0, 12);
        $display("seq back-to-back: beats=%0d dones=%0d", hs_count - hs0, done_count - d0);

        // Sixth beat (stage 1, addr 1/3, index 2) held for 3 stalled cycles
        hs0 = hs_count;
        d0  = done_count;
        stall_left = 3;
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 60 && done_count == d0; i++) begin
            rdy = 1'b1;
            if (bus.tw_valid && beat_idx == 5 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            cycle(rdy, 1'b0);
        end
        chk("stall_cycles_used", stall_left, 0);
        chk("stall_beats", hs_count - hs0, 12);
        chk("stall_dones", done_count - d0, 1);
        $display("seq stall: beats=%0d dones=%0d", hs_count - hs0, done_count - d0);
        cycle(1'b1, 1'b0);

        // start pulsed on the fifth beat is ignored
        hs0 = hs_count;
        d0  = done_count;
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 60 && done_count == d0; i++) begin
            st = bus.tw_valid && (beat_idx == 4);
            cycle(1'b1, st);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        chk("busy_start_beats", hs_count - hs0, 12);
        chk("busy_start_dones", done_count - d0, 1);
        $display("seq start-while-busy: beats=%0d dones=%0d", hs_count - hs0, done_count - d0);

        // Reset on beat 7 aborts; restart runs from beat 0
        d0 = done_count;
        cycle(1'b1, 1'b1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.tw_valid && beat_idx == 7) found = 1;
            else cycle(1'b1, 1'b0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_beat7: got no beat 7 expected beat 7 on output");
        end
        #2 rst_n = 1'b0;
        #1 chk_all_zero("abort");
        beat_idx = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort_no_done", done_count - d0, 0);
        hs0 = hs_count;
        cycle(1'b1, 1'b1);
        run_to_done(1'b0, 40);
        chk("restart_beats", hs_count - hs0, 12);
        $display("seq reset-abort: restart beats=%0d", hs_count - hs0);

        // Random back-pressure over 20 sequences
        for (int n = 0; n < 20; n++) begin
            cycle(1'b1, 1'b0);
            hs0 = hs_count;
            d0  = done_count;
            cycle(1'($urandom_range(0, 1)), 1'b1);
            run_to_done(1'b1, 400);
            chk($sformatf("rand_beats_%0d", n), hs_count - hs0, 12);
            chk($sformatf("rand_dones_%0d", n), done_count - d0, 1);
            $display("seq random %0d: beats=%0d dones=%0d", n, hs_count - hs0, done_count - d0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
